tdc_meas_ctrl: RTL

TDC_MEAS_CTRL -- requirements
Module: tdc_meas_ctrl

---
 rtl/tdc_meas_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/tdc_meas_ctrl.sv
// rtl/tdc_meas_ctrl.sv - TDC measurement sequencer: launch, settle, capture, accumulate, result handshake
// Optional TDC_CTRL_BUBBLE_FIX_EN: decode dl_code as popcount instead of first-zero position.
module tdc_meas_ctrl #(
    parameter int DL_LEN      = 32,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 255,
    localparam int CNT_W      = $clog2(DL_LEN + 1),
    localparam int RES_W      = CNT_W + 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_pls_src,
    input  logic              cfg_bypass,
    input  logic [1:0]        cfg_nsamp_log2,
    input  logic              start,
    output logic              busy,
    input  logic              pg_in,
    output logic              pls_launch,
    output logic              pls_src_sel,
    output logic              bypass_sel,
    input  logic [DL_LEN-1:0] dl_code,
    output logic              dl_sample,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              err_timeout
);

    typedef enum logic [2:0] {IDLE, ARM, LAUNCH, SETTLE, CAPTURE, DONE} state_t;

    state_t           state_q;
    logic             pls_launch_q, dl_sample_q, res_valid_q, err_timeout_q;
    logic             pls_src_q, bypass_q, pg_prev_q;
    logic [2:0]       samp_left_q;
    logic [3:0]       settle_q;
    logic [7:0]       wait_q;
    logic [RES_W-1:0] acc_q, res_data_q;
    logic [CNT_W-1:0] code_cnt_d;

    function automatic logic [CNT_W-1:0] decode(input logic [DL_LEN-1:0] code);
        logic [CNT_W-1:0] n;
`ifndef TDC_CTRL_BUBBLE_FIX_EN
        logic run;
        run = 1'b1;
`endif
        n = '0;
        for (int i = 0; i < DL_LEN; i++) begin
`ifdef TDC_CTRL_BUBBLE_FIX_EN
            if (code[i]) n = n + CNT_W'(1);
`else
            run = run & code[i];
            if (run) n = n + CNT_W'(1);
`endif
        end
        return n;
    endfunction

    always_comb begin
        code_cnt_d = decode(dl_code);
    end

    // res_data/res_valid are loaded on the first DONE cycle, giving the result its own register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pls_launch_q  <= 1'b0;
            dl_sample_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            pls_src_q     <= 1'b0;
            bypass_q      <= 1'b0;
            pg_prev_q     <= 1'b0;
            samp_left_q   <= '0;
            settle_q      <= '0;
            wait_q        <= '0;
            acc_q         <= '0;
            res_data_q    <= '0;
        end else begin
            pg_prev_q    <= pg_in;
            pls_launch_q <= 1'b0;
            dl_sample_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pls_src_q     <= cfg_pls_src;
                        bypass_q      <= cfg_bypass;
                        samp_left_q   <= (3'd1 << cfg_nsamp_log2) - 3'd1;
                        acc_q         <= '0;
                        err_timeout_q <= 1'b0;
                        wait_q        <= '0;
                        state_q       <= ARM;
                    end
                end
                ARM: begin
                    if (pls_src_q) begin
                        pls_launch_q <= 1'b1;
                        state_q      <= LAUNCH;
                    end else if (pg_in && !pg_prev_q) begin
                        settle_q <= '0;
                        state_q  <= SETTLE;
                    end else if (wait_q == 8'(TIMEOUT_CYC - 1)) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                LAUNCH: begin
                    settle_q <= '0;
                    state_q  <= SETTLE;
                end
                SETTLE: begin
                    if (settle_q == 4'(SETTLE_CYC - 1)) begin
                        dl_sample_q <= 1'b1;
                        state_q     <= CAPTURE;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                CAPTURE: begin
                    acc_q <= acc_q + RES_W'(code_cnt_d);
                    if (samp_left_q == 3'd0) begin
                        state_q <= DONE;
                    end else begin
                        samp_left_q <= samp_left_q - 3'd1;
                        wait_q      <= '0;
                        state_q     <= ARM;
                    end
                end
                DONE: begin
                    if (!res_valid_q) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= acc_q;
                    end else if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign pls_launch  = pls_launch_q;
    assign dl_sample   = dl_sample_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign err_timeout = err_timeout_q;
    assign pls_src_sel = pls_src_q;
    assign bypass_sel  = bypass_q;

endmodule
